// File: rtl/rc6_bus_adapter.sv
// rc6_bus_adapter
// Host-side front end for the RC6 coprocessor. A 32-bit register bus loads the
// 256-bit key and 128-bit block, commands key load / encryption, and reads the
// captured ciphertext back. The sequencer strobes the coprocessor and then
// waits for its busy flag to rise and fall again.
//
// Ports:
//   inClk, inReset        clock, synchronous active-low reset
//   inWr/inRd/inAddr      host write/read strobes and word address
//   inWrData, outRdData   host write data, registered read data
//   outRdValid            read data valid (one cycle after inRd)
//   outKey, outData       key/plaintext registers driven to the coprocessor
//   outKeyWr, outDataWr   one-cycle load strobes
//   inBusy, inResult      coprocessor busy flag and ciphertext
//   outIrq                completion/error interrupt level
//
// Build option: RC6_BUS_IRQ_EN enables outIrq; otherwise it is tied low.
module rc6_bus_adapter (
    input  logic         inClk,
    input  logic         inReset,
    input  logic         inWr,
    input  logic         inRd,
    input  logic [4:0]   inAddr,
    input  logic [31:0]  inWrData,
    output logic [31:0]  outRdData,
    output logic         outRdValid,
    output logic [255:0] outKey,
    output logic [127:0] outData,
    output logic         outKeyWr,
    output logic         outDataWr,
    input  logic         inBusy,
    input  logic [127:0] inResult,
    output logic         outIrq
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_KEY_STB, ST_KEY_WAIT_HI, ST_KEY_WAIT_LO,
        ST_DAT_STB, ST_DAT_WAIT_HI, ST_DAT_WAIT_LO
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   result_q, result_d;
    logic           keyValid_q, keyValid_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           encPend_q, encPend_d;
    logic [31:0]    rdData_q, rdData_d;
    logic           rdValid_q;

    logic idle, wrKey, wrData, wrCtrl, clr, cmdKey, cmdEnc;
    logic errSet, doneSet, doneClr;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        data_d     = data_q;
        result_d   = result_q;
        keyValid_d = keyValid_q;
        encPend_d  = encPend_q;
        errSet     = 1'b0;
        doneSet    = 1'b0;
        doneClr    = 1'b0;

        idle   = (state_q == ST_IDLE);
        wrKey  = inWr && (inAddr[4:3] == 2'b00);
        wrData = inWr && (inAddr[4:2] == 3'b010);
        wrCtrl = inWr && (inAddr == 5'h0C);
        clr    = wrCtrl && inWrData[2];
        cmdKey = wrCtrl && inWrData[0];
        cmdEnc = wrCtrl && inWrData[1];

        // Operand registers only change while the coprocessor is not using them.
        if (wrKey) begin
            if (idle) begin
                key_d[{inAddr[2:0], 5'b0} +: 32] = inWrData;
                keyValid_d = 1'b0;
            end else begin
                errSet = 1'b1;
            end
        end
        if (wrData) begin
            if (idle) data_d[{inAddr[1:0], 5'b0} +: 32] = inWrData;
            else      errSet = 1'b1;
        end
        if (!idle && (cmdKey || cmdEnc)) errSet = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (cmdKey) begin
                    state_d   = ST_KEY_STB;
                    encPend_d = cmdEnc;
                    doneClr   = cmdEnc;
                end else if (cmdEnc) begin
                    if (keyValid_q) begin
                        state_d = ST_DAT_STB;
                        doneClr = 1'b1;
                    end else begin
                        errSet = 1'b1;
                    end
                end
            end
            ST_KEY_STB:     state_d = ST_KEY_WAIT_HI;
            ST_KEY_WAIT_HI: if (inBusy) state_d = ST_KEY_WAIT_LO;
            ST_KEY_WAIT_LO: begin
                if (!inBusy) begin
                    keyValid_d = 1'b1;
                    encPend_d  = 1'b0;
                    state_d    = encPend_q ? ST_DAT_STB : ST_IDLE;
                end
            end
            ST_DAT_STB:     state_d = ST_DAT_WAIT_HI;
            ST_DAT_WAIT_HI: if (inBusy) state_d = ST_DAT_WAIT_LO;
            ST_DAT_WAIT_LO: begin
                if (!inBusy) begin
                    result_d = inResult;
                    doneSet  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default:        state_d = ST_IDLE;
        endcase

        // Setting events take priority over CLR.
        done_d = done_q;
        if (clr || doneClr) done_d = 1'b0;
        if (doneSet)        done_d = 1'b1;
        error_d = error_q;
        if (clr)    error_d = 1'b0;
        if (errSet) error_d = 1'b1;

        // Reads see pre-update register values, so a result read in the
        // capture cycle returns the previous result.
        rdData_d = rdData_q;
        if (inRd) begin
            if (inAddr[4:3] == 2'b00)
                rdData_d = key_q[{inAddr[2:0], 5'b0} +: 32];
            else if (inAddr[4:2] == 3'b010)
                rdData_d = data_q[{inAddr[1:0], 5'b0} +: 32];
            else if (inAddr == 5'h0D)
                rdData_d = {28'd0, error_q, done_q, keyValid_q, !idle};
            else if (inAddr[4:2] == 3'b100)
                rdData_d = result_q[{inAddr[1:0], 5'b0} +: 32];
            else
                rdData_d = '0;
        end
    end

    always_ff @(posedge inClk) begin
        if (!inReset) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            data_q     <= '0;
            result_q   <= '0;
            keyValid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            encPend_q  <= 1'b0;
            rdData_q   <= '0;
            rdValid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            data_q     <= data_d;
            result_q   <= result_d;
            keyValid_q <= keyValid_d;
            done_q     <= done_d;
            error_q    <= error_d;
            encPend_q  <= encPend_d;
            rdData_q   <= rdData_d;
            rdValid_q  <= inRd;
        end
    end

    assign outKey     = key_q;
    assign outData    = data_q;
    assign outKeyWr   = (state_q == ST_KEY_STB);
    assign outDataWr  = (state_q == ST_DAT_STB);
    assign outRdData  = rdData_q;
    assign outRdValid = rdValid_q;

`ifdef RC6_BUS_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (clr)               irq_d = 1'b0;
        if (doneSet || errSet) irq_d = 1'b1;
    end

    always_ff @(posedge inClk) begin
        if (!inReset) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign outIrq = irq_q;
`else
    assign outIrq = 1'b0;
`endif

endmodule

// File: tb/tb_rc6_bus_adapter.sv
module tb_rc6_bus_adapter;

    logic         inClk = 1'b0;
    logic         inReset, inWr, inRd, inBusy;
    logic [4:0]   inAddr;
    logic [31:0]  inWrData, outRdData;
    logic         outRdValid, outKeyWr, outDataWr, outIrq;
    logic [255:0] outKey;
    logic [127:0] outData, inResult;

`ifdef RC6_BUS_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    always #5 inClk = ~inClk;

    rc6_bus_adapter dut (
        .inClk(inClk), .inReset(inReset), .inWr(inWr), .inRd(inRd),
        .inAddr(inAddr), .inWrData(inWrData), .outRdData(outRdData),
        .outRdValid(outRdValid), .outKey(outKey), .outData(outData),
        .outKeyWr(outKeyWr), .outDataWr(outDataWr), .inBusy(inBusy),
        .inResult(inResult), .outIrq(outIrq)
    );

    int unsigned n_vec = 0, n_err = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard of expected read responses.
    logic [31:0] expq[$];
    string       nameq[$];

    int unsigned  negCnt = 0, lastCmdNeg = 0;
    int unsigned  keyStbCnt = 0, dataStbCnt = 0, keyStbNeg = 0, dataStbNeg = 0;
    logic [255:0] keyAtStb = '0;

    always @(negedge inClk) begin
        negCnt++;
        if (inWr === 1'b1 && inAddr == 5'h0C) lastCmdNeg = negCnt;
        if (outKeyWr === 1'b1) begin
            keyStbCnt++;
            keyStbNeg = negCnt;
            keyAtStb  = outKey;
        end
        if (outDataWr === 1'b1) begin
            dataStbCnt++;
            dataStbNeg = negCnt;
        end
        if (outRdValid === 1'b1) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_read: got %0h expected no response", outRdData);
            end else begin
                check(nameq.pop_front(), {224'd0, outRdData}, {224'd0, expq.pop_front()});
            end
        end
    end

    // Coprocessor stub: busy rises 2 cycles after a strobe, stays 40 cycles.
    int unsigned  stubDone = 0;
    logic [127:0] xorv = {4{32'hA5A5A5A5}};
    logic         isData;
    initial begin
        inBusy   = 1'b0;
        inResult = '0;
        forever begin
            @(negedge inClk);
            if (outKeyWr === 1'b1 || outDataWr === 1'b1) begin
                isData = outDataWr;
                repeat (2) @(posedge inClk);
                #1 inBusy = 1'b1;
                repeat (40) @(posedge inClk);
                #1;
                if (isData) inResult = outData ^ xorv;
                inBusy = 1'b0;
                stubDone++;
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge inClk); #1;
        inWr = 1'b1; inAddr = a; inWrData = d;
        @(posedge inClk); #1;
        inWr = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
        @(posedge inClk); #1;
        inRd = 1'b1; inAddr = a;
        expq.push_back(e);
        nameq.push_back(nm);
        @(posedge inClk); #1;
        inRd = 1'b0;
    endtask

    task automatic wait_stub(input int unsigned target, input string nm);
        int unsigned budget = 300;
        while (stubDone < target && budget > 0) begin
            @(posedge inClk);
            budget--;
        end
        check(nm, 256'(stubDone >= target), 256'd1);
        repeat (2) @(posedge inClk);
        #1;
    endtask

    task automatic wait_busy(input string nm);
        int unsigned budget = 100;
        while (inBusy !== 1'b1 && budget > 0) begin
            @(posedge inClk);
            budget--;
        end
        check(nm, {255'd0, inBusy}, 256'd1);
    endtask

    logic [255:0] expKey;
    int unsigned  cmdNeg;
    logic [31:0]  dw[4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0BADF00D};
    logic [31:0]  rw[4] = '{32'h7B081B4A, 32'hA486E0C2, 32'h2C0E684A, 32'hAE0855A8};

    initial begin
        // Reset held with a write pending: nothing may be captured.
        inReset = 1'b0; inWr = 1'b1; inRd = 1'b0;
        inAddr = 5'h00; inWrData = 32'hFFFFFFFF;
        repeat (2) @(posedge inClk);
        @(negedge inClk);
        check("rst_rddata", {224'd0, outRdData}, '0);
        check("rst_rdvalid", {255'd0, outRdValid}, '0);
        check("rst_keywr", {255'd0, outKeyWr}, '0);
        check("rst_datawr", {255'd0, outDataWr}, '0);
        check("rst_irq", {255'd0, outIrq}, '0);
        check("rst_key", outKey, '0);
        check("rst_data", {128'd0, outData}, '0);
        @(posedge inClk); #1;
        inWr = 1'b0; inReset = 1'b1;
        rd(5'h0D, 32'h0, "status_reset");
        rd(5'h00, 32'h0, "key0_reset");

        // ENCRYPT without a valid key.
        wr(5'h0C, 32'h2);
        rd(5'h0D, 32'h8, "status_enc_nokey");
        check("no_strobe_nokey", 256'(keyStbCnt + dataStbCnt), 256'd0);
        check("irq_on_error", {255'd0, outIrq}, {255'd0, IRQ_ON});
        wr(5'h0C, 32'h4);
        rd(5'h0D, 32'h0, "status_clr");
        check("irq_after_clr", {255'd0, outIrq}, '0);

        // Key load.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] w;
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            expKey[32*k +: 32] = w;
            wr(5'(k), w);
        end
        rd(5'h03, 32'h0F0E0D0C, "key3_readback");
        wr(5'h0C, 32'h1);
        cmdNeg = lastCmdNeg;
        rd(5'h0D, 32'h1, "status_active");
        wait_stub(1, "key_busy_timeout");
        check("key_stb_count", 256'(keyStbCnt), 256'd1);
        check("key_stb_timing", 256'(keyStbNeg), 256'(cmdNeg + 1));
        check("key_at_strobe", keyAtStb, expKey);
        rd(5'h0D, 32'h2, "status_key_loaded");

        // Chained key load + encrypt.
        for (int d = 0; d < 4; d++) wr(5'(8 + d), dw[d]);
        wr(5'h0C, 32'h3);
        cmdNeg = lastCmdNeg;
        wait_stub(3, "chain_busy_timeout");
        check("chain_key_stb", 256'(keyStbCnt), 256'd2);
        check("chain_key_timing", 256'(keyStbNeg), 256'(cmdNeg + 1));
        check("chain_data_stb", 256'(dataStbCnt), 256'd1);
        check("chain_order", 256'(dataStbNeg > keyStbNeg), 256'd1);
        for (int d = 0; d < 4; d++) rd(5'(16 + d), rw[d], "result_word");
        rd(5'h0D, 32'h6, "status_done");
        check("irq_on_done", {255'd0, outIrq}, {255'd0, IRQ_ON});
        wr(5'h0C, 32'h4);
        check("irq_cleared", {255'd0, outIrq}, '0);
        rd(5'h0D, 32'h2, "status_after_clr");

        // Data write while waiting for busy to fall is rejected.
        wr(5'h0C, 32'h2);
        wait_busy("dat_busy_rise");
        wr(5'h08, 32'h55555555);
        check("data_locked", {224'd0, outData[31:0]}, {224'd0, 32'hDEADBEEF});
        rd(5'h08, 32'hDEADBEEF, "data0_locked");
        wait_stub(4, "dat_busy_timeout");
        rd(5'h0D, 32'hE, "status_done_err");
        rd(5'h10, 32'h7B081B4A, "result0_again");
        check("dat_stb_count", 256'(dataStbCnt), 256'd2);
        check("irq_done_err", {255'd0, outIrq}, {255'd0, IRQ_ON});

        // Unmapped addresses.
        wr(5'h0E, 32'h12345678);
        rd(5'h1F, 32'h0, "unmapped_1f");
        rd(5'h0E, 32'h0, "unmapped_0e");
        rd(5'h0D, 32'hE, "status_unmapped_wr");

        // Reset in the middle of a key sequence.
        wr(5'h0C, 32'h5);
        wait_busy("rst_busy_rise");
        @(posedge inClk); #1 inReset = 1'b0;
        @(posedge inClk); #1 inReset = 1'b1;
        check("rst_mid_keywr", {255'd0, outKeyWr}, '0);
        check("rst_mid_irq", {255'd0, outIrq}, '0);
        rd(5'h0D, 32'h0, "status_rst_mid");
        rd(5'h00, 32'h0, "key0_rst_mid");
        rd(5'h10, 32'h0, "result0_rst_mid");
        wait_stub(5, "rst_busy_timeout");
        check("no_strobe_after_rst", 256'(keyStbCnt + dataStbCnt), 256'd5);

        repeat (3) @(posedge inClk);
        #1;
        check("reads_outstanding", 256'(expq.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rc6_bus_adapter.md
# rc6_bus_adapter

Host-side front end for the RC6 encryption coprocessor. Converts a 32-bit register-style write/read bus into the wide key/data load strobes the coprocessor expects. Sequences key load and block encryption against the coprocessor's busy flag and captures the 128-bit result into readable registers. Sits directly upstream of the coprocessor; its downstream ports connect one-to-one to the coprocessor's key, data, strobe, busy and result ports.

## Interface
Parameters:
- none

Ports (reset is synchronous, active-low; one clock):
- inClk  in  1  system clock, all logic on rising edge
- inReset  in  1  synchronous active-low reset
- inWr  in  1  host write strobe, one word per cycle
- inRd  in  1  host read strobe
- inAddr  in  5  word address (map below)
- inWrData  in  32  host write data
- outRdData  out  32  read data, registered
- outRdValid  out  1  high one cycle after an accepted read
- outKey  out  256  key to coprocessor; word k drives bits [32k+31:32k]
- outData  out  128  plaintext to coprocessor; word d drives bits [32d+31:32d]
- outKeyWr  out  1  one-cycle key load strobe
- outDataWr  out  1  one-cycle data load strobe
- inBusy  in  1  coprocessor busy
- inResult  in  128  coprocessor ciphertext output
- outIrq  out  1  completion interrupt (only with RC6_BUS_IRQ_EN)

## Operation
- Address map:
  - 0x00–0x07 key words 0–7 (R/W)
  - 0x08–0x0B data words 0–3 (R/W)
  - 0x0C control (W): bit0 LOAD_KEY, bit1 ENCRYPT, bit2 CLR (clears done/error)
  - 0x0D status (R): bit0 active (FSM not IDLE), bit1 keyValid, bit2 done, bit3 error
  - 0x10–0x13 result words 0–3 (R)
  - other addresses: reads return 0, writes ignored
- Reads have no side effects.
- FSM states: IDLE, KEY_STB, KEY_WAIT_HI, KEY_WAIT_LO, DAT_STB, DAT_WAIT_HI, DAT_WAIT_LO.
  - IDLE + LOAD_KEY → KEY_STB.
  - IDLE + ENCRYPT only: keyValid=1 → DAT_STB; keyValid=0 → error=1, stay IDLE.
  - LOAD_KEY and ENCRYPT in the same write: key sequence runs first, then continues to DAT_STB; the pending-encrypt flag is kept internally.
  - KEY_STB: outKeyWr=1 for one cycle → KEY_WAIT_HI.
  - *_WAIT_HI: stay until inBusy=1 → *_WAIT_LO.
  - KEY_WAIT_LO: on inBusy=0 → keyValid=1; go to DAT_STB if encrypt is pending, else IDLE.
  - DAT_STB: outDataWr=1 for one cycle → DAT_WAIT_HI.
  - DAT_WAIT_LO: on inBusy=0, capture inResult into the result registers, done=1 → IDLE.
- Host writes to 0x00–0x0B, or a LOAD_KEY/ENCRYPT command, while FSM ≠ IDLE: ignored, error=1.
- CLR is accepted in any state.
- A key-word write in IDLE clears keyValid.
- A new ENCRYPT clears done when it leaves IDLE.
- If CLR and an error-setting event occur in the same cycle, error=1 (set wins).

## Timing
- Reset values: outRdData=0, outRdValid=0, outKeyWr=0, outDataWr=0, outIrq=0. Key, data and result registers = 0. keyValid=0, done=0, error=0, FSM=IDLE.
- Reset mid-sequence forces IDLE on the next edge; strobes drop immediately at that edge.
- Command write at cycle N → strobe high during cycle N+1.
- Busy falling edge sampled at cycle M → result registers and done valid from cycle M+1.
- Read at cycle N → outRdData/outRdValid valid in cycle N+1.
- A read of result words in the cycle the result is captured returns the old value.
- Simultaneous inWr and inRd: both serviced.
- outKey/outData are register outputs and are stable whenever strobes are high.

## Configuration
- RC6_BUS_IRQ_EN defined:
  - outIrq is a level, set together with done, cleared by CLR or reset.
  - error also asserts outIrq.
- Undefined:
  - outIrq is tied to 0; no extra logic.

## Test plan
- Reset: hold inReset=0 for 2 cycles with inWr=1, addr 0x00, data 0xFFFFFFFF → all outputs 0; status read returns 0x0.
- Key load: write words 0x03020100, 0x07060504, …, 0x1F1E1D1C to 0x00–0x07, then 0x0C=0x1. Stub asserts busy 2 cycles after the strobe and holds it 40 cycles. Expect:
  - outKeyWr is a single pulse the cycle after the command.
  - outKey = 0x1F1E1D1C…03020100.
  - status = 0x2 after busy falls.
- Chained: write data 0xDEADBEEF, 0x01234567, 0x89ABCDEF, 0x0BADF00D, then 0x0C=0x3. Stub returns result = data XOR {4{0xA5A5A5A5}}. Expect:
  - Key strobe, then data strobe.
  - Result words 0x7B081B4A, 0xA486E0C2, 0x2C0E684A, 0xAE0855A8.
  - status = 0x6.
- ENCRYPT with keyValid=0 (after reset) → no strobe, status = 0x8; 0x0C=0x4 → status = 0x0.
- Write to 0x08 while in DAT_WAIT_LO → outData unchanged, error=1, sequence still completes with done=1.
- With RC6_BUS_IRQ_EN: outIrq rises the cycle after busy falls and clears one cycle after the CLR write. Without the macro: outIrq stays 0 throughout.
